// File: rtl/mips_bus_arbiter_if.sv
// Avalon-style word-addressed memory port: 'master' drives the request, 'slave' answers it.
interface mips_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master (m0 data, m1 ifetch) to one-slave bus arbiter; 1-cycle grant latency, one IDLE between transfers,
// slave waitrequest stalls only the granted master. ARB_ROUND_ROBIN_EN selects round-robin ties, else m0 wins ties.
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    mips_bus_arbiter_if.slave         m0,
    mips_bus_arbiter_if.slave         m1,
    mips_bus_arbiter_if.master        mem,
    output logic [1:0]                grant
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       req0;
    logic       req1;
    logic       done0;
    logic       done1;

    assign req0  = m0.read | m0.write;
    assign req1  = m1.read | m1.write;
    assign done0 = (state == GNT0) && req0 && !mem.waitrequest;
    assign done1 = (state == GNT1) && req1 && !mem.waitrequest;

`ifdef ARB_ROUND_ROBIN_EN
    // Index of the master that last completed; reset to 1 so m0 wins the first tie.
    logic last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (done0) begin
            last_grant <= 1'b0;
        end else if (done1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    next_state = last_grant ? GNT0 : GNT1;
`else
                    next_state = GNT0;
`endif
                end else if (req0) begin
                    next_state = GNT0;
                end else if (req1) begin
                    next_state = GNT1;
                end
            end
            // Completion and abort (request dropped) both release the bus; never pre-empted.
            GNT0: if (!req0 || !mem.waitrequest) next_state = IDLE;
            GNT1: if (!req1 || !mem.waitrequest) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        mem.address    = {ADDR_W{1'b0}};
        mem.read       = 1'b0;
        mem.write      = 1'b0;
        mem.writedata  = {DATA_W{1'b0}};
        mem.byteenable = {(DATA_W/8){1'b0}};
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        grant          = 2'b00;
        case (state)
            GNT0: begin
                mem.address    = m0.address;
                mem.read       = m0.read;
                mem.write      = m0.write;
                mem.writedata  = m0.writedata;
                mem.byteenable = m0.byteenable;
                m0.waitrequest = mem.waitrequest;
                grant          = 2'b01;
            end
            GNT1: begin
                mem.address    = m1.address;
                mem.read       = m1.read;
                mem.write      = m1.write;
                mem.writedata  = m1.writedata;
                mem.byteenable = m1.byteenable;
                m1.waitrequest = mem.waitrequest;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the granted master's completion cycle makes it meaningful.
    assign m0.readdata = mem.readdata;
    assign m1.readdata = mem.readdata;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
module tb_mips_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    int         checks = 0;
    int         failures = 0;

    mips_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    mips_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
    mips_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    mips_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .mem   (mem_bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    task automatic clear_masters();
        m0_bus.address = '0; m0_bus.read = 1'b0; m0_bus.write = 1'b0;
        m0_bus.writedata = '0; m0_bus.byteenable = '0;
        m1_bus.address = '0; m1_bus.read = 1'b0; m1_bus.write = 1'b0;
        m1_bus.writedata = '0; m1_bus.byteenable = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_masters();
        mem_bus.readdata = '0;
        mem_bus.waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if ({m0_bus.waitrequest, m1_bus.waitrequest} !== 2'b11) begin failures++; $display("FAIL reset_wait: got %b want 11", {m0_bus.waitrequest, m1_bus.waitrequest}); end
        checks++; if ({mem_bus.read, mem_bus.write} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b want 00", {mem_bus.read, mem_bus.write}); end
        reset = 1'b0;
    endtask

    task automatic test_m0_read();
        @(negedge clk);
        m0_bus.read = 1'b1; m0_bus.address = 32'hBFC00000;
        mem_bus.waitrequest = 1'b0; mem_bus.readdata = 32'hDEADBEEF;
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rd_c0_grant: got %b want 00", grant); end
        checks++; if (m0_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL rd_c0_wait: got %b want 1", m0_bus.waitrequest); end
        checks++; if (mem_bus.read !== 1'b0) begin failures++; $display("FAIL rd_c0_read: got %b want 0", mem_bus.read); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rd_c1_grant: got %b want 01", grant); end
        checks++; if (mem_bus.read !== 1'b1 || mem_bus.address !== 32'hBFC00000) begin failures++; $display("FAIL rd_c1_bus: got read=%b addr=%h want 1 bfc00000", mem_bus.read, mem_bus.address); end
        checks++; if (m0_bus.waitrequest !== 1'b0 || m1_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL rd_c1_wait: got m0=%b m1=%b want 0 1", m0_bus.waitrequest, m1_bus.waitrequest); end
        checks++; if (m0_bus.readdata !== 32'hDEADBEEF || m1_bus.readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_c1_rdata: got %h %h want deadbeef", m0_bus.readdata, m1_bus.readdata); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rd_c2_grant: got %b want 00", grant); end
        clear_masters();
    endtask

    task automatic test_m1_write_wait();
        @(negedge clk);
        m1_bus.write = 1'b1; m1_bus.writedata = 32'h00000004; m1_bus.byteenable = 4'b1111;
        m1_bus.address = 32'h00001000;
        mem_bus.waitrequest = 1'b1;
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL wr_c0_grant: got %b want 00", grant); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (grant !== 2'b10 || mem_bus.write !== 1'b1 || m1_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL wr_stall%0d: got grant=%b write=%b wait=%b want 10 1 1", i, grant, mem_bus.write, m1_bus.waitrequest); end
            checks++; if (mem_bus.writedata !== 32'h00000004 || mem_bus.byteenable !== 4'b1111) begin failures++; $display("FAIL wr_data%0d: got %h %b want 00000004 1111", i, mem_bus.writedata, mem_bus.byteenable); end
        end
        @(negedge clk);
        mem_bus.waitrequest = 1'b0;
        #1;
        checks++; if (grant !== 2'b10 || m1_bus.waitrequest !== 1'b0) begin failures++; $display("FAIL wr_done: got grant=%b wait=%b want 10 0", grant, m1_bus.waitrequest); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL wr_idle: got %b want 00", grant); end
        clear_masters();
    endtask

    task automatic test_contention();
        logic [1:0] exp_seq [7];
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`else
        exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`endif
        @(negedge clk);
        m0_bus.read = 1'b1; m0_bus.address = 32'h00000100;
        m1_bus.read = 1'b1; m1_bus.address = 32'h00000200;
        mem_bus.waitrequest = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            checks++; if (grant !== exp_seq[i]) begin failures++; $display("FAIL tie_seq%0d: got %b want %b", i, grant, exp_seq[i]); end
        end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL tie_end: got %b want 00", grant); end
        clear_masters();
    endtask

    task automatic test_no_preempt();
        @(negedge clk);
        m1_bus.read = 1'b1; m1_bus.address = 32'h00000040;
        mem_bus.waitrequest = 1'b1;
        @(negedge clk);
        m0_bus.read = 1'b1; m0_bus.address = 32'h00000080;
        #1;
        checks++; if (grant !== 2'b10 || mem_bus.address !== 32'h00000040) begin failures++; $display("FAIL np_hold0: got grant=%b addr=%h want 10 00000040", grant, mem_bus.address); end
        checks++; if (m0_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL np_m0wait: got %b want 1", m0_bus.waitrequest); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL np_hold1: got %b want 10", grant); end
        mem_bus.waitrequest = 1'b0;
        #1;
        checks++; if (m1_bus.waitrequest !== 1'b0) begin failures++; $display("FAIL np_m1wait: got %b want 0", m1_bus.waitrequest); end
        @(negedge clk);
        m1_bus.read = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL np_idle: got %b want 00", grant); end
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01 || mem_bus.address !== 32'h00000080) begin failures++; $display("FAIL np_m0: got grant=%b addr=%h want 01 00000080", grant, mem_bus.address); end
        @(negedge clk);
        clear_masters();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m0_bus.write = 1'b1; m0_bus.address = 32'h00000300; m0_bus.writedata = 32'h12345678; m0_bus.byteenable = 4'b0011;
        mem_bus.waitrequest = 1'b1;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01 || mem_bus.write !== 1'b1) begin failures++; $display("FAIL rm_pre: got grant=%b write=%b want 01 1", grant, mem_bus.write); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (grant !== 2'b00 || mem_bus.read !== 1'b0 || mem_bus.write !== 1'b0) begin failures++; $display("FAIL rm_async: got grant=%b rd=%b wr=%b want 00 0 0", grant, mem_bus.read, mem_bus.write); end
        checks++; if ({m0_bus.waitrequest, m1_bus.waitrequest} !== 2'b11 || mem_bus.address !== 32'h0 || mem_bus.writedata !== 32'h0 || mem_bus.byteenable !== 4'b0) begin failures++; $display("FAIL rm_bus: got wait=%b addr=%h wd=%h be=%b want 11 0 0 0", {m0_bus.waitrequest, m1_bus.waitrequest}, mem_bus.address, mem_bus.writedata, mem_bus.byteenable); end
        @(negedge clk);
        reset = 1'b0;
        clear_masters();
    endtask

    task automatic test_abort();
        @(negedge clk);
        m0_bus.read = 1'b1; m0_bus.address = 32'h00000500;
        mem_bus.waitrequest = 1'b1;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL ab_grant: got %b want 01", grant); end
        m0_bus.read = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL ab_idle: got %b want 00", grant); end
        // A tie right after the abort must still go to m0 (abort leaves the tie-break history alone).
        m0_bus.read = 1'b1; m1_bus.read = 1'b1;
        mem_bus.waitrequest = 1'b0;
        @(negedge clk); #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL ab_tie: got %b want 01", grant); end
        clear_masters();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_m1_write_wait();
        test_contention();
        test_no_preempt();
        test_reset_mid();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
